// File: rtl/pit_pkg.sv
// Register map, CTRL bit positions and small helpers shared by the PIT block.
// Build option: PIT_PRESCALER_EN enables the clock prescaler (see pit16_wb).
package pit_pkg;

  localparam logic [31:0] PIT_BASE_ADDR = 32'hF000_000C;
  localparam logic [31:0] PIT_CTRL_OFS  = 32'h0000_0000;
  localparam logic [31:0] PIT_COUNT_OFS = 32'h0000_0002;

  localparam int PIT_EN_BIT   = 0;
  localparam int PIT_PER_BIT  = 1;
  localparam int PIT_IEN_BIT  = 2;
  localparam int PIT_PEND_BIT = 15;

  typedef struct packed {
    logic pend;
    logic ien;
    logic per;
    logic en;
  } pit_ctrl_t;

  // CTRL as seen on the bus; unimplemented bits read 0.
  function automatic logic [15:0] pit_ctrl_word(input pit_ctrl_t c);
    logic [15:0] w;
    w               = '0;
    w[PIT_EN_BIT]   = c.en;
    w[PIT_PER_BIT]  = c.per;
    w[PIT_IEN_BIT]  = c.ien;
    w[PIT_PEND_BIT] = c.pend;
    return w;
  endfunction

  function automatic logic [15:0] pit_merge(input logic [15:0] old_val,
                                            input logic [15:0] new_val,
                                            input logic [1:0]  sel);
    return {sel[1] ? new_val[15:8] : old_val[15:8],
            sel[0] ? new_val[7:0]  : old_val[7:0]};
  endfunction

endpackage

// File: rtl/pit_prescaler.sv
// Divides clk into a one-cycle tick every PRESCALE cycles while en is high.
// rst is active-low and asynchronous; clr restarts the division from zero.
module pit_prescaler #(
  parameter int PRESCALE = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(PRESCALE - 1);

  logic [15:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr || !en || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/pit16_wb.sv
// 16-bit Wishbone programmable interval timer with level interrupt output.
// Build option: PIT_PRESCALER_EN instantiates pit_prescaler; otherwise every enabled cycle ticks.
module pit16_wb
  import pit_pkg::*;
#(
  parameter int PRESCALE = 100
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [1:0]  wb_sel_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        irq_o
);

  // Handshake: a request is cyc & stb; it is accepted on the edge that raises
  // the registered ack, ack drops on the following edge, so every access takes
  // two cycles and write side effects commit on the accepting edge.
  logic acc, sel_count, wr_ctrl, wr_reload, rd;
  assign acc       = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign sel_count = (wb_adr_i[1] == PIT_COUNT_OFS[1]);
  assign wr_ctrl   = acc & wb_we_i & ~sel_count;
  assign wr_reload = acc & wb_we_i & sel_count;
  assign rd        = acc & ~wb_we_i;

  pit_ctrl_t   ctrl, ctrl_d;
  logic [15:0] reload, reload_d, count, count_d, new_reload;
  logic        tick, expire, en_rise, pend_clr, presc_clr;

  assign new_reload = pit_merge(reload, wb_dat_i, wb_sel_i);
  assign en_rise    = wr_ctrl & wb_sel_i[0] & wb_dat_i[PIT_EN_BIT] & ~ctrl.en;
  assign pend_clr   = wr_ctrl & wb_sel_i[1] & wb_dat_i[PIT_PEND_BIT];
  assign presc_clr  = wr_reload | en_rise;
  assign expire     = tick & (count == 16'd0);

`ifdef PIT_PRESCALER_EN
  pit_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk  (clk_i),
    .rst  (rst_i),
    .en   (ctrl.en),
    .clr  (presc_clr),
    .tick (tick)
  );
`else
  logic unused_cfg;
  assign tick       = ctrl.en;
  assign unused_cfg = presc_clr ^ (PRESCALE > 0);
`endif

  logic unused_adr;
  assign unused_adr = ^{wb_adr_i[31:2], wb_adr_i[0]};

  // Later assignments take priority: bus writes override the tick update,
  // while expiry still sets PEND regardless of a concurrent clear.
  always_comb begin
    ctrl_d   = ctrl;
    reload_d = reload;
    count_d  = count;
    if (tick) begin
      if (count != 16'd0) begin
        count_d = count - 16'd1;
      end else if (ctrl.per) begin
        count_d = reload;
      end else begin
        ctrl_d.en = 1'b0;
      end
    end
    if (expire) begin
      ctrl_d.pend = 1'b1;
    end else if (pend_clr) begin
      ctrl_d.pend = 1'b0;
    end
    if (wr_ctrl && wb_sel_i[0]) begin
      ctrl_d.en  = wb_dat_i[PIT_EN_BIT];
      ctrl_d.per = wb_dat_i[PIT_PER_BIT];
      ctrl_d.ien = wb_dat_i[PIT_IEN_BIT];
    end
    if (en_rise) begin
      count_d = reload;
    end
    if (wr_reload) begin
      reload_d = new_reload;
      count_d  = new_reload;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ctrl     <= '0;
      reload   <= '0;
      count    <= '0;
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      irq_o    <= 1'b0;
    end else begin
      ctrl     <= ctrl_d;
      reload   <= reload_d;
      count    <= count_d;
      wb_ack_o <= wb_cyc_i & wb_stb_i & ~wb_ack_o;
      irq_o    <= ctrl.pend & ctrl.ien;
      if (rd) begin
        wb_dat_o <= sel_count ? count : pit_ctrl_word(ctrl);
      end
    end
  end

endmodule

// File: tb/tb_pit16_wb.sv
// Self-checking bench for pit16_wb: directed scenarios plus randomized timer runs
// predicted from the reload/prescale arithmetic.
module tb_pit16_wb;
  import pit_pkg::*;

  localparam int PRESCALE = 4;
`ifdef PIT_PRESCALER_EN
  localparam int P_EFF = PRESCALE;
`else
  localparam int P_EFF = 1;
`endif
  localparam int N_PER = 8 / P_EFF - 1;  // period of exactly 8 cycles
  localparam logic [31:0] CTRL_A = PIT_BASE_ADDR + PIT_CTRL_OFS;
  localparam logic [31:0] CNT_A  = PIT_BASE_ADDR + PIT_COUNT_OFS;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
  logic [31:0] wb_adr_i = '0;
  logic [1:0]  wb_sel_i = '0;
  logic [15:0] wb_dat_i = '0;
  logic [15:0] wb_dat_o;
  logic        wb_ack_o, irq_o;

  pit16_wb #(.PRESCALE(PRESCALE)) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .wb_cyc_i (wb_cyc_i),
    .wb_stb_i (wb_stb_i),
    .wb_we_i  (wb_we_i),
    .wb_adr_i (wb_adr_i),
    .wb_sel_i (wb_sel_i),
    .wb_dat_i (wb_dat_i),
    .wb_dat_o (wb_dat_o),
    .wb_ack_o (wb_ack_o),
    .irq_o    (irq_o)
  );

  // clock / edge counter
  always #5 clk = ~clk;
  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // scoreboard
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  // driver tasks; all start and end 1 time unit after a rising edge
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_until(input int target);
    while (edge_n < target) step(1);
  endtask

  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [15:0] dat,
                         input logic [1:0] sel, output logic [15:0] rdat, output int commit);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
    commit = -1;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (wb_ack_o) begin
        commit = edge_n;
        break;
      end
    end
    rdat = wb_dat_o;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    if (commit < 0) check("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [15:0] dat,
                          input logic [1:0] sel, output int commit);
    logic [15:0] unused_rd;
    wb_xfer(1'b1, adr, dat, sel, unused_rd, commit);
  endtask

  task automatic wb_read(input logic [31:0] adr, output logic [15:0] dat, output int commit);
    wb_xfer(1'b0, adr, 16'h0, 2'b11, dat, commit);
  endtask

  task automatic wait_irq_rise(output int e);
    e = -1;
    for (int i = 0; i < 600; i++) begin
      step(1);
      if (irq_o) begin
        e = edge_n;
        break;
      end
    end
    if (e < 0) check("irq_timeout", 32'd0, 32'd1);
  endtask

  // count value latched by a read that commits on edge r, from the tick arithmetic
  function automatic logic [15:0] model_count(input int r, input int e0, input int n);
    int ticks;
    ticks = (r - 1 - e0) / P_EFF;
    return 16'(n - (ticks % (n + 1)));
  endfunction

  initial begin
    logic [15:0] rd;
    int e0, e, c, r, n, per;

    // reset
    step(3);
    check("rst_ack", {31'd0, wb_ack_o}, 32'd0);
    check("rst_dat", {16'd0, wb_dat_o}, 32'd0);
    check("rst_irq", {31'd0, irq_o}, 32'd0);
    rst_i = 1'b1;
    step(2);
    wb_read(CTRL_A, rd, r);
    check("rst_ctrl", {16'd0, rd}, 32'h0);
    wb_read(CNT_A, rd, r);
    check("rst_count", {16'd0, rd}, 32'h0);

    // one-shot
    wb_write(CNT_A, 16'd3, 2'b11, c);
    wb_write(CTRL_A, 16'h0005, 2'b11, e0);
    wait_irq_rise(e);
    check("oneshot_irq_edge", e, e0 + 4 * P_EFF + 1);
    wb_read(CTRL_A, rd, r);
    check("oneshot_ctrl", {16'd0, rd}, 32'h8004);
    wb_read(CNT_A, rd, r);
    check("oneshot_count", {16'd0, rd}, 32'h0);
    wb_write(CTRL_A, 16'h8000, 2'b10, c);
    check("clr_irq_hold", {31'd0, irq_o}, 32'd1);
    step(1);
    check("clr_irq_drop", {31'd0, irq_o}, 32'd0);

    // periodic, 8-cycle period, five expiries
    wb_write(CNT_A, 16'(N_PER), 2'b11, c);
    wb_write(CTRL_A, 16'h0007, 2'b11, e0);
    for (int k = 1; k <= 5; k++) exp_q.push_back(32'(e0 + 8 * k + 1));
    for (int k = 1; k <= 5; k++) begin
      wait_irq_rise(e);
      check($sformatf("periodic_irq_%0d", k), e, exp_q.pop_front());
      if (k < 5) begin
        wb_write(CTRL_A, 16'h8000, 2'b10, c);
        step(1);
        check($sformatf("periodic_drop_%0d", k), {31'd0, irq_o}, 32'd0);
      end
    end

    // PEND clear on the expiry edge: set wins
    wait_until(e0 + 47);
    wb_write(CTRL_A, 16'h8000, 2'b10, c);
    check("race_commit_edge", c, e0 + 48);
    step(1);
    check("race_irq", {31'd0, irq_o}, 32'd1);
    wb_read(CTRL_A, rd, r);
    check("race_ctrl", {16'd0, rd}, 32'h8007);

    // EN 1->0 write on the expiry edge
    wb_write(CTRL_A, 16'h8000, 2'b10, c);
    wait_until(e0 + 55);
    wb_write(CTRL_A, 16'h0004, 2'b01, c);
    check("enoff_commit_edge", c, e0 + 56);
    wb_read(CTRL_A, rd, r);
    check("enoff_ctrl", {16'd0, rd}, 32'h8004);

    // byte lanes
    wb_write(CNT_A, 16'h0012, 2'b11, c);
    wb_write(CNT_A, 16'hABCD, 2'b10, c);
    wb_read(CNT_A, rd, r);
    check("lane_hi", {16'd0, rd}, 32'hAB12);
    wb_write(CNT_A, 16'h5577, 2'b01, c);
    wb_read(CNT_A, rd, r);
    check("lane_lo", {16'd0, rd}, 32'hAB77);
    wb_write(CTRL_A, 16'h8000, 2'b11, c);
    step(2);
    check("idle_irq", {31'd0, irq_o}, 32'd0);

    // randomized runs
    for (int t = 0; t < 6; t++) begin
      n   = $urandom_range(8 / P_EFF - 1, 24 / P_EFF - 1);
      per = $urandom_range(0, 1);
      wb_write(CNT_A, 16'(n), 2'b11, c);
      wb_write(CTRL_A, 16'(5 | (per << 1)), 2'b11, e0);
      wait_irq_rise(e);
      check($sformatf("rnd%0d_first", t), e, e0 + (n + 1) * P_EFF + 1);
      if (per != 0) begin
        wb_write(CTRL_A, 16'h8000, 2'b10, c);
        step(1);
        check($sformatf("rnd%0d_drop", t), {31'd0, irq_o}, 32'd0);
        wait_irq_rise(e);
        check($sformatf("rnd%0d_second", t), e, e0 + 2 * (n + 1) * P_EFF + 1);
        wb_read(CTRL_A, rd, r);
        check($sformatf("rnd%0d_ctrl", t), {16'd0, rd}, 32'h8007);
        step($urandom_range(0, 7));
        wb_read(CNT_A, rd, r);
        check($sformatf("rnd%0d_count", t), {16'd0, rd}, {16'd0, model_count(r, e0, n)});
      end else begin
        wb_read(CTRL_A, rd, r);
        check($sformatf("rnd%0d_ctrl", t), {16'd0, rd}, 32'h8004);
        wb_read(CNT_A, rd, r);
        check($sformatf("rnd%0d_count", t), {16'd0, rd}, 32'h0);
      end
      wb_write(CTRL_A, 16'h8000, 2'b11, c);
      wb_write(CTRL_A, 16'h8000, 2'b10, c);
      step(2);
      check($sformatf("rnd%0d_idle", t), {31'd0, irq_o}, 32'd0);
    end

    // asynchronous reset mid-count with irq high and an access in flight
    wb_write(CNT_A, 16'(N_PER), 2'b11, c);
    wb_write(CTRL_A, 16'h0007, 2'b11, e0);
    wait_irq_rise(e);
    step(2);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = CNT_A;
    #2 rst_i = 1'b0;
    #1;
    check("arst_irq", {31'd0, irq_o}, 32'd0);
    check("arst_ack", {31'd0, wb_ack_o}, 32'd0);
    check("arst_dat", {16'd0, wb_dat_o}, 32'd0);
    step(1);
    check("arst_ack_hold", {31'd0, wb_ack_o}, 32'd0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    step(2);
    rst_i = 1'b1;
    step(1);
    check("arst_ack_after", {31'd0, wb_ack_o}, 32'd0);
    wb_read(CTRL_A, rd, r);
    check("arst_ctrl", {16'd0, rd}, 32'h0);
    wb_read(CNT_A, rd, r);
    check("arst_count", {16'd0, rd}, 32'h0);
    step(20);
    check("arst_irq_quiet", {31'd0, irq_o}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pit16_wb.md
# pit16_wb

Programmable interval timer for the Marin SoC. It is a 16-bit Wishbone slave that occupies the 4-byte PIT window at 0xF000000C. It counts down a software-loaded reload value on a prescaled clock and raises a level interrupt when the count expires. `irq_o` feeds one `irq_i` input of the `mpic_wb` interrupt controller, which forwards it to the MoxieLite core.

## Interface
- `PRESCALE`, default 100: `clk_i` cycles per count tick; legal range 1..65535.
- `clk_i`  in  1: CPU clock; all logic on the rising edge.
- `rst_i`  in  1: asynchronous, active-low reset.
- `wb_cyc_i`  in  1: Wishbone cycle.
- `wb_stb_i`  in  1: Wishbone strobe.
- `wb_we_i`  in  1: write enable.
- `wb_adr_i`  in  32: byte address; only bit 1 is decoded.
- `wb_sel_i`  in  2: byte lanes; bit 1 selects [15:8], bit 0 selects [7:0].
- `wb_dat_i`  in  16: write data.
- `wb_dat_o`  out  16: read data.
- `wb_ack_o`  out  1: transfer acknowledge.
- `irq_o`  out  1: level interrupt to the PIC.

## Operation
- Registers are selected by `wb_adr_i[1]`:
  - 0 = CTRL.
  - 1 = COUNT/RELOAD. A write sets RELOAD; a read returns the live COUNT.
- CTRL bits:
  - [0] EN.
  - [1] PERIODIC.
  - [2] IEN.
  - [15] PEND: read-only status; writing 1 clears it, writing 0 has no effect.
  - All other bits read 0.
- Writes honour `wb_sel_i` per byte.
  - A CTRL write with `sel[0]`=0 leaves bits [2:0] unchanged.
  - A CTRL write with `sel[1]`=0 does not touch PEND.
- Any RELOAD write does all of the following: updates the written bytes of RELOAD, loads COUNT from the new RELOAD value, and clears the prescaler.
- A CTRL write that takes EN from 0 to 1 loads COUNT from RELOAD and clears the prescaler.
- Tick generation: while EN=1 the prescaler counts 0..PRESCALE-1, and a tick occurs on the cycle where prescaler = PRESCALE-1. While EN=0 the prescaler holds at 0.
- On a tick:
  - If COUNT ≠ 0, COUNT decrements by 1.
  - If COUNT = 0 (expiry): PEND is set. If PERIODIC=1, COUNT reloads from RELOAD; otherwise COUNT stays 0 and EN clears.
- With RELOAD = N, expiry happens after N+1 ticks. RELOAD = 0 expires on every tick.
- `irq_o` is a register that takes `PEND & IEN`. It is cleared only through PEND or IEN, never by EN.
- Simultaneous events:
  - Expiry on the same edge as a PEND write-1-clear: set wins, PEND stays 1.
  - Expiry on the same edge as a RELOAD write: the write wins. COUNT and the prescaler load from the write, but PEND is still set.
  - EN 1→0 write on the same edge as expiry: EN ends at 0 and PEND is set.

## Timing
- Reset values: `wb_ack_o`=0, `wb_dat_o`=0, `irq_o`=0; CTRL=0, RELOAD=0, COUNT=0, prescaler=0.
- Reset asserted mid-count clears all state immediately. No tick and no ack is produced until the first edge after release.
- Wishbone handshake:
  - `wb_ack_o` is registered: it asserts on the edge after `cyc & stb` are sampled high and drops the following edge (`ack <= cyc & stb & ~ack`).
  - Every access takes 2 cycles. Back-to-back accesses see ack on alternate cycles.
  - Write side effects commit on the same edge that raises ack.
  - `wb_dat_o` is registered with the ack and holds until the next read.
- First expiry occurs (N+1)·PRESCALE cycles after the edge that commits EN=1. PEND is visible on that edge; `irq_o` asserts one cycle later.
- After a PEND clear (or IEN 1→0) commits, `irq_o` drops one cycle later.

## Configuration
- `PIT_PRESCALER_EN` defined: prescaler behaves as described above.
- `PIT_PRESCALER_EN` undefined: the prescaler is not instantiated and every enabled cycle is a tick, equivalent to PRESCALE=1. The PRESCALE parameter is ignored; first expiry is N+1 cycles after EN.

## Structure
- Package `pit_pkg` holds:
  - register offsets `PIT_CTRL_OFS`, `PIT_COUNT_OFS`;
  - CTRL bit indices `PIT_EN_BIT`, `PIT_PER_BIT`, `PIT_IEN_BIT`, `PIT_PEND_BIT`;
  - the base address constant 0xF000000C.
- Sub-module `pit_prescaler` has inputs clk, rst, en, clr and outputs a one-cycle tick. It is instantiated only under `PIT_PRESCALER_EN`.

## Test plan
All scenarios use PRESCALE=4 unless noted.
- One-shot: write RELOAD=3, then CTRL=0x0005 → PEND sets 16 cycles after the EN-commit edge and `irq_o` at 17; EN reads back 0; COUNT reads 0.
- Periodic: RELOAD=1, CTRL=0x0007 → PEND at cycle 8. Clear by writing 0x8000, then expiry again at cycle 16 (8 cycles after the first); 5 expiries land at 8, 16, 24, 32, 40.
- Race: align a PEND write-1-clear with the expiry edge → PEND reads 1 afterwards and `irq_o` stays high.
- Byte lanes: write RELOAD=0xABCD with sel=2'b10 when RELOAD=0x0012 → RELOAD=0xAB12, and a COUNT read returns 0xAB12.
- Reset: pull `rst_i` low while COUNT=5 and `irq_o`=1 → `irq_o`, `wb_ack_o`, CTRL and COUNT are 0 in the same cycle, with no ack for the aborted cycle.
- Macro off (`PIT_PRESCALER_EN` undefined): RELOAD=2, EN=1 → PEND 3 cycles after EN commits.
